// File: rtl/mem_uart_streamer_pkg.sv
// Shared types and helpers for the memory-to-UART frame streamer.
package mem_uart_streamer_pkg;

    // Controller states:
    //   ST_IDLE  | waiting for start after reset or abort
    //   ST_HDR   | loading the frame header byte
    //   ST_RD    | memory address stable, waiting out the read latency
    //   ST_LOAD  | selecting the next payload byte from the word register
    //   ST_SEND  | byte ready, waiting for uart_tx to be idle
    //   ST_GUARD | one cycle for uart_tx to raise its busy flag
    //   ST_WAIT  | waiting for uart_tx to finish, then choosing the next step
    //   ST_CSUM  | loading the checksum byte
    //   ST_DONE  | frame finished, waiting for a new start
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_RD,
        ST_LOAD,
        ST_SEND,
        ST_GUARD,
        ST_WAIT,
        ST_CSUM,
        ST_DONE
    } state_e;

    // What the byte currently held in tx_data is, so WAIT knows where to go.
    typedef enum logic [1:0] {
        KIND_HDR,
        KIND_DATA,
        KIND_CSUM
    } byte_kind_e;

    localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;

    // Total bytes on the wire for one frame.
    function automatic int unsigned frame_len(input bit          header_en,
                                              input int unsigned num_words,
                                              input int unsigned word_w,
                                              input bit          chksum_en);
        return 32'(header_en) + num_words * (word_w / 8) + 32'(chksum_en);
    endfunction

endpackage

// File: rtl/mem_uart_streamer_byte_serializer.sv
// Holds one memory word and hands it out a byte at a time, MSB first,
// while keeping the running 8-bit payload checksum.
module mem_uart_streamer_byte_serializer #(
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              capture_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              load_i,
    input  logic              dec_i,
    output logic [7:0]        byte_o,
    output logic              idx_zero_o,
    output logic [7:0]        chksum_o
);

    localparam int unsigned BPW     = WORD_W / 8;
    localparam logic [1:0]  IDX_TOP = 2'(BPW - 1);

    logic [WORD_W-1:0] word_q;
    logic [1:0]        idx_q;
    logic [7:0]        sum_q;
    logic [31:0]       word_ext;

    assign word_ext   = 32'(word_q);
    assign byte_o     = word_ext[{idx_q, 3'b000} +: 8];
    assign idx_zero_o = (idx_q == 2'd0);
    assign chksum_o   = sum_q;

    // Word capture, byte index countdown and checksum accumulation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            idx_q  <= 2'd0;
            sum_q  <= 8'd0;
        end else begin
            if (capture_i) begin
                word_q <= word_i;
                idx_q  <= IDX_TOP;
            end else if (dec_i) begin
                idx_q <= idx_q - 2'd1;
            end
            if (clear_i) begin
                sum_q <= 8'd0;
            end else if (load_i) begin
                sum_q <= sum_q + byte_o;
            end
        end
    end

endmodule

// File: rtl/mem_uart_streamer.sv
// Streams a block of result memory out over uart_tx as one frame:
// optional header, payload bytes MSB-first per word, optional checksum.
module mem_uart_streamer
    import mem_uart_streamer_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned NUM_WORDS   = 3969,
    parameter int unsigned WORD_W      = 8,
    parameter int unsigned RD_LAT      = 2,
    parameter bit          HEADER_EN   = 1'b1,
    parameter logic [7:0]  HEADER_BYTE = DEFAULT_HEADER_BYTE,
    parameter bit          CHKSUM_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_enable,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done,
    output logic              completed,
    output logic [15:0]       byte_count
);

    localparam int unsigned FRAME_LEN    = frame_len(HEADER_EN, NUM_WORDS, WORD_W, CHKSUM_EN);
    // Short frames can never reach the saturation point, so the compare folds away.
    localparam bit          CAN_SATURATE = (FRAME_LEN >= 32'd65535);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    // RD is held for RD_LAT+1 cycles so the capture edge follows the data becoming valid.
    localparam logic [2:0]  RD_WAIT = 3'(RD_LAT);

    state_e            state_q, state_d;
    byte_kind_e        kind_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        tx_data_q;
    logic              tx_enable_q;
    logic              done_q;
    logic              completed_q;
    logic [15:0]       byte_count_q;
    logic [2:0]        rd_cnt_q;

    logic start_acc, hdr_ld, rd_cap, byte_ld, csum_ld, send_fire, idx_dec, addr_inc;
    logic done_entry;
    logic [7:0] ser_byte, ser_sum;
    logic ser_idx_zero;

    mem_uart_streamer_byte_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .clk_i      (clk),
        .rst_ni     (reset),
        .clear_i    (start_acc),
        .capture_i  (rd_cap),
        .word_i     (mem_rdata),
        .load_i     (byte_ld),
        .dec_i      (idx_dec),
        .byte_o     (ser_byte),
        .idx_zero_o (ser_idx_zero),
        .chksum_o   (ser_sum)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and one-cycle datapath strobes; abort overrides everything.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        hdr_ld    = 1'b0;
        rd_cap    = 1'b0;
        byte_ld   = 1'b0;
        csum_ld   = 1'b0;
        send_fire = 1'b0;
        idx_dec   = 1'b0;
        addr_inc  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        start_acc = 1'b1;
                        state_d   = HEADER_EN ? ST_HDR : ST_RD;
                    end
                end
                ST_HDR: begin
                    hdr_ld  = 1'b1;
                    state_d = ST_SEND;
                end
                ST_RD: begin
                    if (rd_cnt_q == 3'd0) begin
                        rd_cap  = 1'b1;
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    byte_ld = 1'b1;
                    state_d = ST_SEND;
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        send_fire = 1'b1;
                        state_d   = ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (!tx_busy) begin
                        if (kind_q == KIND_HDR) begin
                            state_d = ST_RD;
                        end else if (kind_q == KIND_CSUM) begin
                            state_d = ST_DONE;
                        end else if (!ser_idx_zero) begin
                            idx_dec = 1'b1;
                            state_d = ST_LOAD;
                        end else if (addr_q == LAST_ADDR) begin
                            state_d = CHKSUM_EN ? ST_CSUM : ST_DONE;
                        end else begin
                            addr_inc = 1'b1;
                            state_d  = ST_RD;
                        end
                    end
                end
                ST_CSUM: begin
                    csum_ld = 1'b1;
                    state_d = ST_SEND;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign done_entry = (state_d == ST_DONE) && (state_q != ST_DONE);

    // Address counter, byte register, handshake strobe and frame status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q       <= '0;
            tx_data_q    <= 8'd0;
            kind_q       <= KIND_DATA;
            tx_enable_q  <= 1'b0;
            done_q       <= 1'b0;
            completed_q  <= 1'b0;
            byte_count_q <= 16'd0;
        end else begin
            tx_enable_q <= send_fire;
            done_q      <= done_entry;
            if (start_acc) begin
                addr_q <= '0;
            end else if (addr_inc) begin
                addr_q <= addr_q + 1'b1;
            end
            if (hdr_ld) begin
                tx_data_q <= HEADER_BYTE;
                kind_q    <= KIND_HDR;
            end else if (byte_ld) begin
                tx_data_q <= ser_byte;
                kind_q    <= KIND_DATA;
            end else if (csum_ld) begin
                tx_data_q <= ser_sum;
                kind_q    <= KIND_CSUM;
            end
            if (start_acc) begin
                completed_q <= 1'b0;
            end else if (done_entry) begin
                completed_q <= 1'b1;
            end
            if (start_acc) begin
                byte_count_q <= 16'd0;
            end else if (send_fire && (!CAN_SATURATE || byte_count_q != 16'hFFFF)) begin
                byte_count_q <= byte_count_q + 16'd1;
            end
        end
    end

    // Read-latency down-counter; reloads whenever the FSM is outside RD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_cnt_q <= RD_WAIT;
        end else if (state_q != ST_RD) begin
            rd_cnt_q <= RD_WAIT;
        end else if (rd_cnt_q != 3'd0) begin
            rd_cnt_q <= rd_cnt_q - 3'd1;
        end
    end

    assign mem_addr   = addr_q;
    assign tx_data    = tx_data_q;
    assign tx_enable  = tx_enable_q;
    assign done       = done_q;
    assign completed  = completed_q;
    assign byte_count = byte_count_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_mem_uart_streamer.sv
// Bench for mem_uart_streamer: three instances (base config, RD_LAT=4,
// single-byte config), each with its own memory and uart_tx model.
module tb_mem_uart_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_v [3];
    logic abort_v [3];
    logic hold_v [3];
    logic tx_busy_v [3];

    logic [3:0]  mem_addr_w [3];
    logic [7:0]  tx_data_w [3];
    logic        tx_en_w [3];
    logic        busy_w [3];
    logic        done_w [3];
    logic        completed_w [3];
    logic [15:0] byte_count_w [3];

    logic [7:0] frame_v [3][16];
    int         flen [3];
    logic [7:0] log_v [3][16];
    int         pos [3];
    int         busy_cnt [3];
    int         done_cnt [3];
    int         clr_seq [3];
    int         seen [3];
    logic [7:0] last_sent [3];
    logic [7:0] lit [10];

    int total = 0;
    int bad = 0;

    function automatic int lane_ww(input int g);
        return (g == 2) ? 8 : 16;
    endfunction
    function automatic int lane_nw(input int g);
        return (g == 2) ? 1 : 4;
    endfunction
    function automatic int lane_rl(input int g);
        return (g == 1) ? 4 : 2;
    endfunction
    function automatic bit lane_hf(input int g);
        return (g != 2);
    endfunction

    function automatic logic [15:0] memtab(input int g, input int a);
        if (g == 2) return 16'h005C;
        case (a)
            0: return 16'h0102;
            1: return 16'h0304;
            2: return 16'h0506;
            3: return 16'hFFFF;
            default: return 16'hDEAD;
        endcase
    endfunction

    task automatic chk(input bit ok, input string nm, input int act, input int exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int WW = lane_ww(g);
        localparam int RL = lane_rl(g);
        logic [15:0]   pipe [RL];
        logic [WW-1:0] rdata;

        assign rdata = pipe[RL-1][WW-1:0];

        always @(posedge clk) begin
            pipe[0] <= memtab(g, int'(mem_addr_w[g]));
            for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
        end

        mem_uart_streamer #(
            .ADDR_W      (4),
            .NUM_WORDS   (lane_nw(g)),
            .WORD_W      (WW),
            .RD_LAT      (RL),
            .HEADER_EN   (lane_hf(g)),
            .HEADER_BYTE (8'hA5),
            .CHKSUM_EN   (lane_hf(g))
        ) dut (
            .clk        (clk),
            .reset      (rst_n),
            .start      (start_v[g]),
            .abort      (abort_v[g]),
            .mem_addr   (mem_addr_w[g]),
            .mem_rdata  (rdata),
            .tx_data    (tx_data_w[g]),
            .tx_enable  (tx_en_w[g]),
            .tx_busy    (tx_busy_v[g]),
            .busy       (busy_w[g]),
            .done       (done_w[g]),
            .completed  (completed_w[g]),
            .byte_count (byte_count_w[g])
        );
    end

    // Compare process plus uart_tx model (10-cycle busy per byte, optional extra hold).
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (!rst_n) begin
                pos[g]       = 0;
                busy_cnt[g]  = 0;
                tx_busy_v[g] = hold_v[g];
            end else begin
                if (clr_seq[g] != seen[g]) begin
                    seen[g] = clr_seq[g];
                    pos[g]  = 0;
                end
                chk(int'(mem_addr_w[g]) < lane_nw(g), "addr_range", int'(mem_addr_w[g]), lane_nw(g) - 1);
                if (tx_en_w[g]) begin
                    chk(!tx_busy_v[g], "en_while_busy", 1, 0);
                    if (pos[g] < flen[g]) begin
                        chk(tx_data_w[g] == frame_v[g][pos[g]], "byte",
                            int'(tx_data_w[g]), int'(frame_v[g][pos[g]]));
                        log_v[g][pos[g]] = tx_data_w[g];
                    end else begin
                        chk(1'b0, "extra_byte", pos[g], flen[g]);
                    end
                    pos[g]++;
                    last_sent[g] = tx_data_w[g];
                    busy_cnt[g]  = 10;
                end else begin
                    if (tx_busy_v[g])
                        chk(tx_data_w[g] == last_sent[g], "tx_data_hold",
                            int'(tx_data_w[g]), int'(last_sent[g]));
                    if (busy_cnt[g] > 0) busy_cnt[g]--;
                end
                if (done_w[g]) begin
                    chk(pos[g] == flen[g], "done_len", pos[g], flen[g]);
                    chk(int'(byte_count_w[g]) == flen[g], "done_count", int'(byte_count_w[g]), flen[g]);
                    chk(completed_w[g] == 1'b1, "done_completed", int'(completed_w[g]), 1);
                    done_cnt[g]++;
                end
                tx_busy_v[g] = (busy_cnt[g] > 0) || hold_v[g];
            end
        end
    end

    task automatic start_frame(input bit m0, input bit m1, input bit m2);
        @(negedge clk);
        if (m0) begin clr_seq[0]++; start_v[0] = 1'b1; end
        if (m1) begin clr_seq[1]++; start_v[1] = 1'b1; end
        if (m2) begin clr_seq[2]++; start_v[2] = 1'b1; end
        @(negedge clk);
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int target);
        for (int i = 0; i < 4000; i++) begin
            if (done_cnt[g] >= target) break;
            @(posedge clk);
        end
        chk(done_cnt[g] >= target, "done_timeout", done_cnt[g], target);
        @(negedge clk);
    endtask

    task automatic wait_pos(input int g, input int n);
        for (int i = 0; i < 4000; i++) begin
            if (pos[g] >= n) break;
            @(posedge clk);
        end
        chk(pos[g] >= n, "pos_timeout", pos[g], n);
    endtask

    task automatic check_reset_outputs(input int g);
        chk(mem_addr_w[g] == 4'd0, "rst_addr", int'(mem_addr_w[g]), 0);
        chk(tx_data_w[g] == 8'd0, "rst_tx_data", int'(tx_data_w[g]), 0);
        chk(tx_en_w[g] == 1'b0, "rst_tx_enable", int'(tx_en_w[g]), 0);
        chk(done_w[g] == 1'b0, "rst_done", int'(done_w[g]), 0);
        chk(completed_w[g] == 1'b0, "rst_completed", int'(completed_w[g]), 0);
        chk(byte_count_w[g] == 16'd0, "rst_byte_count", int'(byte_count_w[g]), 0);
        chk(busy_w[g] == 1'b0, "rst_busy", int'(busy_w[g]), 0);
    endtask

    task automatic check_lit_frame(input int g, input string nm);
        chk(pos[g] == 10, {nm, "_len"}, pos[g], 10);
        for (int k = 0; k < 10; k++)
            chk(log_v[g][k] == lit[k], nm, int'(log_v[g][k]), int'(lit[k]));
        chk(byte_count_w[g] == 16'd10, {nm, "_count"}, int'(byte_count_w[g]), 10);
        chk(completed_w[g] == 1'b1, {nm, "_completed"}, int'(completed_w[g]), 1);
        chk(busy_w[g] == 1'b0, {nm, "_busy"}, int'(busy_w[g]), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int d0;
        logic [15:0] w;
        logic [7:0]  bt;
        logic [7:0]  sum;

        rst_n = 1'b0;
        for (int g = 0; g < 3; g++) begin
            start_v[g] = 1'b0; abort_v[g] = 1'b0; hold_v[g] = 1'b0; tx_busy_v[g] = 1'b0;
            pos[g] = 0; busy_cnt[g] = 0; done_cnt[g] = 0; clr_seq[g] = 0; seen[g] = 0;
            last_sent[g] = 8'd0;
        end
        lit = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hFF, 8'hFF, 8'h13};

        // Expected frames from the frame rules: header, words MSB-first, payload sum.
        for (int g = 0; g < 3; g++) begin
            k = 0;
            sum = 8'd0;
            if (lane_hf(g)) begin frame_v[g][k] = 8'hA5; k++; end
            for (int a = 0; a < lane_nw(g); a++) begin
                w = memtab(g, a);
                for (int b = lane_ww(g) / 8 - 1; b >= 0; b--) begin
                    bt = 8'(w >> (8 * b));
                    frame_v[g][k] = bt;
                    sum = sum + bt;
                    k++;
                end
            end
            if (lane_hf(g)) begin frame_v[g][k] = sum; k++; end
            flen[g] = k;
        end

        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) check_reset_outputs(g);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk(busy_w[0] == 1'b0, "idle_busy", int'(busy_w[0]), 0);
        chk(pos[0] == 0, "idle_no_tx", pos[0], 0);

        // Basic frame on all three configurations.
        start_frame(1'b1, 1'b1, 1'b1);
        wait_done(0, 1);
        check_lit_frame(0, "basic");
        wait_done(1, 1);
        check_lit_frame(1, "rdlat4");
        wait_done(2, 1);
        chk(pos[2] == 1, "single_len", pos[2], 1);
        chk(log_v[2][0] == 8'h5C, "single_byte", int'(log_v[2][0]), 8'h5C);
        chk(byte_count_w[2] == 16'd1, "single_count", int'(byte_count_w[2]), 1);
        chk(done_cnt[2] == 1, "single_done_cnt", done_cnt[2], 1);
        repeat (30) @(negedge clk);
        chk(done_cnt[0] == 1, "basic_one_done", done_cnt[0], 1);

        // Handshake: stretch uart busy by 50 cycles after the third byte.
        start_frame(1'b1, 1'b0, 1'b0);
        wait_pos(0, 3);
        hold_v[0] = 1'b1;
        d0 = pos[0];
        repeat (50) @(posedge clk);
        chk(pos[0] == d0, "hold_no_enable", pos[0], d0);
        hold_v[0] = 1'b0;
        wait_done(0, 2);
        check_lit_frame(0, "hold");

        // Abort after the fourth byte.
        start_frame(1'b1, 1'b0, 1'b0);
        wait_pos(0, 4);
        @(negedge clk);
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        chk(busy_w[0] == 1'b0, "abort_idle", int'(busy_w[0]), 0);
        chk(tx_en_w[0] == 1'b0, "abort_no_en", int'(tx_en_w[0]), 0);
        d0 = done_cnt[0];
        repeat (60) @(negedge clk);
        chk(pos[0] == 4, "abort_no_more_bytes", pos[0], 4);
        chk(done_cnt[0] == d0, "abort_no_done", done_cnt[0], d0);
        chk(completed_w[0] == 1'b0, "abort_completed", int'(completed_w[0]), 0);
        for (int i = 0; i < 100 && tx_busy_v[0]; i++) @(negedge clk);
        start_frame(1'b1, 1'b0, 1'b0);
        wait_done(0, 3);
        check_lit_frame(0, "after_abort");

        // Abort and start together while idle: abort wins.
        @(negedge clk);
        abort_v[0] = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        start_v[0] = 1'b0;
        chk(busy_w[0] == 1'b0, "abort_start_idle", int'(busy_w[0]), 0);
        repeat (20) @(negedge clk);
        chk(pos[0] == 10, "abort_start_no_tx", pos[0], 10);
        chk(completed_w[0] == 1'b1, "abort_start_completed", int'(completed_w[0]), 1);

        // Reset in the middle of a frame.
        start_frame(1'b1, 1'b0, 1'b0);
        wait_pos(0, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk(busy_w[0] == 1'b0, "post_reset_idle", int'(busy_w[0]), 0);
        chk(pos[0] == 0, "post_reset_no_tx", pos[0], 0);
        chk(byte_count_w[0] == 16'd0, "post_reset_count", int'(byte_count_w[0]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_uart_streamer.md
Name: mem_uart_streamer

Overview:
- Streams a block of result memory (pooling/inference output BRAM) out over the existing uart_tx, byte by byte, with an optional framing header and trailing checksum.
- Parametrised successor to the fixed 8-bit, 63x63, fixed-wait controller:
  - configurable word width, word count and BRAM read latency;
  - proper tx_busy handshake;
  - restart after completion;
  - abort.
- Sits between the memory read port and uart_tx, on the UART clock domain.

Parameters:
- ADDR_W, 12, memory address width.
- NUM_WORDS, 3969, words per frame (1..2**ADDR_W).
- WORD_W, 8, memory word width; multiple of 8, max 32.
- RD_LAT, 2, cycles from mem_addr change to valid mem_rdata (1..4).
- HEADER_EN, 1, send HEADER_BYTE before the payload.
- HEADER_BYTE, 8'hA5, frame header value.
- CHKSUM_EN, 1, send an 8-bit checksum after the payload.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled only in IDLE or DONE.
- abort  in  1  synchronous abort; highest priority after reset.
- mem_addr  out  ADDR_W  memory read address.
- mem_rdata  in  WORD_W  memory read data.
- tx_data  out  8  byte presented to uart_tx.
- tx_enable  out  1  one-cycle send strobe to uart_tx.
- tx_busy  in  1  uart_tx busy flag.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle pulse when the last byte of a frame has been accepted.
- completed  out  1  sticky; set with done, cleared by the next accepted start or reset.
- byte_count  out  16  bytes sent in the current frame, including header and checksum.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; mem_addr=0, tx_data=0, tx_enable=0, done=0, completed=0, byte_count=0; checksum accumulator=0.
- Constants:
  - BPW = WORD_W/8 bytes per word.
  - Frame length = HEADER_EN + NUM_WORDS*BPW + CHKSUM_EN bytes.
- States and transitions:
  - IDLE / DONE: on start=1, clear byte_count and checksum, set mem_addr=0, clear completed. Go to HDR if HEADER_EN, else RD.
  - HDR: load HEADER_BYTE into the byte register, go to SEND.
  - RD: wait RD_LAT cycles with mem_addr stable, then capture mem_rdata into the word register and set the byte index to BPW-1. Go to LOAD.
  - LOAD: tx_data = word[8*idx+7 : 8*idx], so bytes go out MSB-first. Add the byte to the checksum (mod 256). Go to SEND.
  - SEND: when tx_busy=0, assert tx_enable for exactly one cycle, byte_count+1, go to GUARD. While tx_busy=1, hold.
  - GUARD: one cycle, so uart_tx can raise tx_busy. Go to WAIT.
  - WAIT: hold while tx_busy=1. Then, in priority order:
    - header just sent: go to RD;
    - checksum just sent: go to DONE;
    - idx>0: idx-1, go to LOAD;
    - last word (mem_addr == NUM_WORDS-1): go to CSUM if CHKSUM_EN, else DONE;
    - otherwise: mem_addr+1, go to RD.
  - CSUM: tx_data = checksum; go to SEND.
  - On entry to DONE: done=1 for one cycle, completed=1.
- tx_data is held stable from LOAD/HDR/CSUM until the next byte is loaded.
- At most one tx_enable per byte. tx_enable never asserts while tx_busy=1.
- abort=1 in any busy state: next cycle state=IDLE, tx_enable=0, completed unchanged, done not pulsed. A byte already in uart_tx finishes on its own.
- abort and start both high in IDLE: abort wins, stays IDLE.
- start held high through DONE: a new frame starts the cycle after DONE. This is intended (continuous mode).
- mem_addr never exceeds NUM_WORDS-1 and does not wrap within a frame.
- byte_count saturates at 16'hFFFF.
- Checksum is the 8-bit sum of payload bytes only; header excluded.

Decomposition:
- Shared package:
  - state encoding (IDLE, HDR, RD, LOAD, SEND, GUARD, WAIT, CSUM, DONE);
  - default HEADER_BYTE;
  - a function computing frame length from the parameters.
- One natural sub-module, byte_serializer: word register, byte index, MSB-first byte select, checksum accumulator.
- FSM, address counter and handshake stay in the top.

Test Plan:
- Use NUM_WORDS=4, WORD_W=16, RD_LAT=2, a memory model holding 16'h0102, 16'h0304, 16'h0506, 16'hFFFF, and a uart_tx model with 10-cycle busy. Unless stated otherwise, HEADER_EN=1 and CHKSUM_EN=1.
- Basic frame: start -> bytes A5,01,02,03,04,05,06,FF,FF,13. Then one done pulse, completed=1, byte_count=10.
- Handshake: hold tx_busy=1 for 50 cycles mid-frame -> no tx_enable during the hold, tx_data stable, frame completes unchanged.
- Abort: abort after the 4th byte -> IDLE next cycle, no further tx_enable, no done. A following start sends the full 10-byte frame again.
- Read latency: RD_LAT=4 -> each captured word matches the memory model; no stale byte is sent.
- Config: HEADER_EN=0, CHKSUM_EN=0, WORD_W=8, NUM_WORDS=1 -> exactly one byte sent, then done.
- Reset: reset low mid-transfer -> all outputs at reset values immediately. After release, the block idles until start.
